// File: rtl/out_channel_checker_pkg.sv
// fpga_check_pkg: shared types and defaults for the out-channel checker
package fpga_check_pkg;
  localparam int DefaultMemoryElementWidth = 12;
  typedef enum logic [1:0] {RUN, PASS, FAIL} check_state_t;
  typedef enum logic [1:0] {NONE, MISMATCH, COUNT, TIMEOUT} fail_cause_t;
endpackage

// File: rtl/out_channel_checker_if.sv
// out_channel_checker_if: valid/ready out-channel word stream from the executor
interface out_channel_checker_if #(parameter int W = fpga_check_pkg::DefaultMemoryElementWidth);
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  modport master(output out_valid, out_data, input out_ready);
  modport slave(input out_valid, out_data, output out_ready);
endinterface

// File: rtl/out_expect_rom.sv
// out_expect_rom: selects expected word idx from the packed table, flags idx < N
module out_expect_rom #(
  parameter int W = 12,
  parameter int N = 4,
  parameter int IW = 8,
  parameter logic [(N > 0 ? N : 1)*W-1:0] Expected = '0
) (
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  word,
  output logic          in_range
);
  always_comb begin
    in_range = idx < IW'(N);
    word = in_range ? Expected[int'(idx)*W +: W] : '0;
  end
endmodule

// File: rtl/out_channel_checker.sv
// out_channel_checker: checks the executor out-channel stream against an expected
// sequence and latches a sticky pass/fail verdict with its cause
module out_channel_checker
  import fpga_check_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NOut = 4,
  parameter logic [NOut*MemoryElementWidth-1:0] Expected = {12'd2, 12'd99, 12'd1, 12'd0},
  parameter int MaxSteps = 42,
  parameter int IndexWidth = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  out_channel_checker_if.slave  ch,
  input  logic                  program_done,
  output logic                  finished,
  output logic                  success,
  output logic [1:0]            fail_cause,
  output logic [IndexWidth-1:0] received_count,
  output logic [IndexWidth-1:0] first_mismatch
);
  localparam int SW = $clog2(MaxSteps + 2);
  localparam logic [IndexWidth-1:0] NOutI = IndexWidth'(NOut);
  localparam logic [SW-1:0] StepCap = SW'(MaxSteps + 1);
  check_state_t state, state_n;
  fail_cause_t cause, cause_n;
  logic [SW-1:0] step, step_n;
  logic [IndexWidth-1:0] count_n, first_n;
  logic mis_seen, mis_n, ovf_seen, ovf_n, mis_now, xfer, in_range;
  logic [MemoryElementWidth-1:0] exp_word;
  out_expect_rom #(
    .W(MemoryElementWidth), .N(NOut), .IW(IndexWidth), .Expected(Expected)
  ) rom (
    .idx(received_count), .word(exp_word), .in_range(in_range)
  );
  assign ch.out_ready = state == RUN;
  assign xfer = ch.out_valid && ch.out_ready;
  assign fail_cause = cause;
  // verdict uses this cycle's post-transfer values, so a word arriving with done is counted first
  always_comb begin
    mis_now = xfer && in_range && ch.out_data != exp_word;
    mis_n = mis_seen || mis_now;
    ovf_n = ovf_seen || (xfer && !in_range);
    count_n = xfer && received_count != NOutI + 1'b1 ? received_count + 1'b1 : received_count;
    first_n = mis_now && !mis_seen ? received_count : first_mismatch;
    step_n = state == RUN && step != StepCap ? step + 1'b1 : step;
    cause_n = state != RUN ? cause :
              mis_n && (program_done || ovf_n) ? MISMATCH :
              (program_done && count_n != NOutI) || ovf_n ? COUNT :
              step_n > SW'(MaxSteps) && !program_done ? TIMEOUT : NONE;
    state_n = state != RUN ? state : cause_n != NONE ? FAIL : program_done ? PASS : RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cause <= NONE;
      step <= '0;
      received_count <= '0;
      first_mismatch <= '0;
      mis_seen <= 1'b0;
      ovf_seen <= 1'b0;
      finished <= 1'b0;
      success <= 1'b0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      step <= step_n;
      received_count <= count_n;
      first_mismatch <= first_n;
      mis_seen <= mis_n;
      ovf_seen <= ovf_n;
      finished <= state_n != RUN;
      success <= state_n == PASS;
    end
  end
endmodule

// File: tb/tb_out_channel_checker.sv
// tb_out_channel_checker: directed scenarios for out_channel_checker with hand-computed verdicts
module tb_out_channel_checker;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic program_done = 1'b0;
  logic finished, success;
  logic [1:0] fail_cause;
  logic [7:0] received_count, first_mismatch;
  int checks = 0;
  int errors = 0;

  out_channel_checker_if #(.W(12)) ch ();

  out_channel_checker dut (
    .clock(clock), .reset(reset), .ch(ch), .program_done(program_done),
    .finished(finished), .success(success), .fail_cause(fail_cause),
    .received_count(received_count), .first_mismatch(first_mismatch)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ch.out_valid = 1'b0;
    ch.out_data = '0;
    program_done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [11:0] w);
    ch.out_valid = 1'b1;
    ch.out_data = w;
    tick();
    ch.out_valid = 1'b0;
  endtask

  task automatic done_pulse();
    program_done = 1'b1;
    tick();
    program_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %0d want 0", finished); end
    checks++; if (success !== 1'b0) begin errors++; $display("FAIL reset_success got %0d want 0", success); end
    checks++; if (fail_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", fail_cause); end
    checks++; if (received_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", received_count); end
    checks++; if (first_mismatch !== 8'd0) begin errors++; $display("FAIL reset_first got %0d want 0", first_mismatch); end
    checks++; if (ch.out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", ch.out_ready); end
  endtask

  task automatic test_pass();
    do_reset();
    send(12'd0); send(12'd1); send(12'd99); send(12'd2);
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL pass_early_finished got %0d want 0", finished); end
    done_pulse();
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL pass_finished got %0d want 1", finished); end
    checks++; if (success !== 1'b1) begin errors++; $display("FAIL pass_success got %0d want 1", success); end
    checks++; if (fail_cause !== 2'd0) begin errors++; $display("FAIL pass_cause got %0d want 0", fail_cause); end
    checks++; if (received_count !== 8'd4) begin errors++; $display("FAIL pass_count got %0d want 4", received_count); end
    checks++; if (ch.out_ready !== 1'b0) begin errors++; $display("FAIL pass_ready got %0d want 0", ch.out_ready); end
    send(12'd5); done_pulse();
    checks++; if (success !== 1'b1 || received_count !== 8'd4) begin errors++; $display("FAIL pass_sticky got success=%0d count=%0d want 1/4", success, received_count); end
  endtask

  task automatic test_mismatch();
    do_reset();
    send(12'd0); send(12'd1); send(12'd98); send(12'd2);
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL mis_early_finished got %0d want 0", finished); end
    done_pulse();
    checks++; if (finished !== 1'b1 || success !== 1'b0) begin errors++; $display("FAIL mis_verdict got fin=%0d succ=%0d want 1/0", finished, success); end
    checks++; if (fail_cause !== 2'd1) begin errors++; $display("FAIL mis_cause got %0d want 1", fail_cause); end
    checks++; if (first_mismatch !== 8'd2) begin errors++; $display("FAIL mis_first got %0d want 2", first_mismatch); end
    checks++; if (received_count !== 8'd4) begin errors++; $display("FAIL mis_count got %0d want 4", received_count); end
    do_reset();
    send(12'd0); send(12'd5); send(12'd99); send(12'd7);
    done_pulse();
    checks++; if (first_mismatch !== 8'd1) begin errors++; $display("FAIL mis_first_latch got %0d want 1", first_mismatch); end
  endtask

  task automatic test_underflow();
    do_reset();
    send(12'd0); send(12'd1); send(12'd99);
    done_pulse();
    checks++; if (finished !== 1'b1 || success !== 1'b0) begin errors++; $display("FAIL under_verdict got fin=%0d succ=%0d want 1/0", finished, success); end
    checks++; if (fail_cause !== 2'd2) begin errors++; $display("FAIL under_cause got %0d want 2", fail_cause); end
    checks++; if (received_count !== 8'd3) begin errors++; $display("FAIL under_count got %0d want 3", received_count); end
    do_reset();
    done_pulse();
    checks++; if (fail_cause !== 2'd2) begin errors++; $display("FAIL nowords_cause got %0d want 2", fail_cause); end
  endtask

  task automatic test_overflow();
    do_reset();
    send(12'd0); send(12'd1); send(12'd99); send(12'd2);
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL ovf_early_finished got %0d want 0", finished); end
    send(12'd7);
    checks++; if (finished !== 1'b1 || success !== 1'b0) begin errors++; $display("FAIL ovf_verdict got fin=%0d succ=%0d want 1/0", finished, success); end
    checks++; if (fail_cause !== 2'd2) begin errors++; $display("FAIL ovf_cause got %0d want 2", fail_cause); end
    checks++; if (ch.out_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %0d want 0", ch.out_ready); end
    checks++; if (received_count !== 8'd5) begin errors++; $display("FAIL ovf_count got %0d want 5", received_count); end
    send(12'd8); done_pulse();
    checks++; if (received_count !== 8'd5 || fail_cause !== 2'd2) begin errors++; $display("FAIL ovf_hold got count=%0d cause=%0d want 5/2", received_count, fail_cause); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 42; i++) tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL tmo_early_finished got %0d want 0", finished); end
    tick();
    checks++; if (finished !== 1'b1 || success !== 1'b0) begin errors++; $display("FAIL tmo_verdict got fin=%0d succ=%0d want 1/0", finished, success); end
    checks++; if (fail_cause !== 2'd3) begin errors++; $display("FAIL tmo_cause got %0d want 3", fail_cause); end
    done_pulse();
    checks++; if (fail_cause !== 2'd3) begin errors++; $display("FAIL tmo_stable got %0d want 3", fail_cause); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    send(12'd0); send(12'd1); send(12'd99);
    program_done = 1'b1;
    send(12'd2);
    program_done = 1'b0;
    checks++; if (finished !== 1'b1 || success !== 1'b1) begin errors++; $display("FAIL same_verdict got fin=%0d succ=%0d want 1/1", finished, success); end
    checks++; if (received_count !== 8'd4) begin errors++; $display("FAIL same_count got %0d want 4", received_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(12'd0); send(12'd1);
    do_reset();
    checks++; if (finished !== 1'b0 || success !== 1'b0 || fail_cause !== 2'd0) begin errors++; $display("FAIL mid_outputs got fin=%0d succ=%0d cause=%0d want 0/0/0", finished, success, fail_cause); end
    checks++; if (received_count !== 8'd0) begin errors++; $display("FAIL mid_count got %0d want 0", received_count); end
    send(12'd0); send(12'd1); send(12'd99); send(12'd2);
    done_pulse();
    checks++; if (finished !== 1'b1 || success !== 1'b1) begin errors++; $display("FAIL mid_pass got fin=%0d succ=%0d want 1/1", finished, success); end
  endtask

  initial begin
    ch.out_valid = 1'b0;
    ch.out_data = '0;
    test_reset();
    test_pass();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_timeout();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
